// File: rtl/mram_pkg.sv
// Shared constants and helpers for the MRAM request controller.
package mram_pkg;

  localparam int MRAM_DATA_WIDTH = 8;
  localparam int MRAM_ADDR_WIDTH = 6;

  // Width needed to count 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mram_rsp_fifo.sv
// Read-response FIFO with wrapping read/write pointers and an occupancy count.
module mram_rsp_fifo
  import mram_pkg::*;
#(
  parameter  int DATA_WIDTH = MRAM_DATA_WIDTH,
  parameter  int DEPTH      = 2,
  localparam int CW         = cnt_width(DEPTH),
  localparam int PW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ptr_next(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_next(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy gates what is visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/mram_req_ctrl.sv
// Request front-end for one MRAM port: credit-based accept, fixed 2-cycle read latency.
module mram_req_ctrl
  import mram_pkg::*;
#(
  parameter  int DATA_WIDTH = MRAM_DATA_WIDTH,
  parameter  int ADDR_WIDTH = MRAM_ADDR_WIDTH,
  parameter  int RSP_DEPTH  = 2,
  localparam int CW         = cnt_width(RSP_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  busy
);

  logic          pending_q, pending_d;
  logic          accept;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;

  // Reads in flight plus buffered, minus the one leaving this cycle.
  always_comb begin
    credit_used = (CW+1)'(fifo_count) + (CW+1)'(pending_q) - (CW+1)'(fifo_pop);
  end

  assign rsp_valid = !rst && !fifo_empty;
  assign fifo_pop  = rsp_valid && rsp_ready;
  assign req_ready = !rst && (credit_used < (CW+1)'(RSP_DEPTH));
  assign accept    = req_valid && req_ready;
  assign fifo_push = pending_q && !fifo_full;

  assign ram_we   = accept && req_we;
  assign ram_addr = req_addr;
  assign ram_data = req_data;

  assign busy = !rst && (pending_q || !fifo_empty);

  always_comb begin
    pending_d = accept && !req_we;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= 1'b0;
    else     pending_q <= pending_d;
  end

  mram_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RSP_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (ram_q),
    .pop       (fifo_pop),
    .pop_data  (rsp_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_mram_req_ctrl.sv
// Self-checking bench for mram_req_ctrl: directed scenarios plus random traffic vs a queue model.
module tb_mram_req_ctrl;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam int D  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_q = '0;
  logic          busy;

  logic [DW-1:0] ram_mem [1<<AW] = '{default: '0};

  mram_req_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_q     (ram_q),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Dual-port RAM port: write commits at the edge, read data registered.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_data;
    ram_q <= ram_mem[ram_addr];
  end

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } rsp_t;

  rsp_t          rq[$];
  logic [DW-1:0] model_mem [1<<AW] = '{default: '0};
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  int            n_acc = 0;
  logic          last_ready, last_valid, last_busy;
  logic [DW-1:0] last_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive, compare every output against the model, advance the model.
  task automatic step(input logic v, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic rr, input logic r);
    logic exp_valid, exp_pop, exp_ready;
    rsp_t e;
    @(negedge clk);
    rst = r; req_valid = v; req_we = we; req_addr = a; req_data = d; rsp_ready = rr;
    #1;
    exp_valid = !r && rq.size() > 0 && rq[0].cyc <= cyc - 2;
    exp_pop   = exp_valid && rr;
    exp_ready = !r && ((rq.size() - (exp_pop ? 1 : 0)) < D);
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    if (exp_valid) check("rsp_data", 32'(rsp_data), 32'(rq[0].data));
    check("busy", 32'(busy), 32'(!r && rq.size() != 0));
    check("ram_we", 32'(ram_we), 32'(v && we && exp_ready));
    check("occ", 32'(dut.u_fifo.count_q <= D), 32'd1);
    last_ready = req_ready; last_valid = rsp_valid; last_data = rsp_data; last_busy = busy;
    if (r) begin
      rq.delete();
    end else begin
      if (exp_pop) void'(rq.pop_front());
      if (v && exp_ready) begin
        n_acc++;
        if (we) model_mem[a] = d;
        else begin
          e.data = model_mem[a];
          e.cyc  = cyc;
          rq.push_back(e);
        end
      end
    end
    cyc++;
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 1'b0, '0, '0, rr, 1'b0);
  endtask

  initial begin
    int acc0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 6'd1, '0, 1'b1, 1'b1);
    check("rst_ready", 32'(last_ready), 32'd0);

    idle(1'b1);
    check("post_rst_ready", 32'(last_ready), 32'd1);

    // Write then read addr 5: response exactly two cycles after accept.
    step(1'b1, 1'b1, 6'd5, 8'hA5, 1'b1, 1'b0);
    step(1'b1, 1'b0, 6'd5, 8'h00, 1'b1, 1'b0);
    idle(1'b1);
    check("a5_early", 32'(last_valid), 32'd0);
    idle(1'b1);
    check("a5_valid", 32'(last_valid), 32'd1);
    check("a5_data", 32'(last_data), 32'hA5);

    // Read immediately after write to the same address.
    step(1'b1, 1'b1, 6'd7, 8'h3C, 1'b1, 1'b0);
    step(1'b1, 1'b0, 6'd7, 8'h00, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    check("a7_data", 32'(last_data), 32'h3C);
    check("a7_valid", 32'(last_valid), 32'd1);

    // Preload and stream four reads back-to-back.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, AW'(i), DW'(8'h10 + i), 1'b1, 1'b0);
    for (int j = 0; j < 6; j++) begin
      step(j < 4, 1'b0, AW'(j % 4), '0, 1'b1, 1'b0);
      if (j < 4) check("stream_ready", 32'(last_ready), 32'd1);
      if (j >= 2) begin
        check("stream_valid", 32'(last_valid), 32'd1);
        check("stream_data", 32'(last_data), 32'(8'h10 + j - 2));
      end
    end

    // Consumer stalled: only RSP_DEPTH reads get in, writes stall too.
    acc0 = n_acc;
    for (int j = 0; j < 6; j++) step(1'b1, 1'b0, AW'(j % 4), '0, 1'b0, 1'b0);
    check("stall_acc", 32'(n_acc - acc0), 32'd2);
    step(1'b1, 1'b1, 6'd9, 8'h77, 1'b0, 1'b0);
    check("stall_wr", 32'(last_ready), 32'd0);
    check("stall_ramwe", 32'(ram_we), 32'd0);
    for (int j = 0; j < 4; j++) idle(1'b1);
    check("drained", 32'(last_busy), 32'd0);

    // Reset with a read in flight discards it; RAM keeps its contents.
    step(1'b1, 1'b0, 6'd2, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    for (int j = 0; j < 3; j++) begin
      idle(1'b1);
      check("rst_novalid", 32'(last_valid), 32'd0);
      check("rst_nobusy", 32'(last_busy), 32'd0);
    end
    step(1'b1, 1'b0, 6'd2, '0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    check("rst_ram_intact", 32'(last_data), 32'h12);

    // Random traffic with occasional resets.
    for (int k = 0; k < 10000; k++) begin
      step(($urandom % 4) != 0, ($urandom % 2) != 0, AW'($urandom_range(0, 15)),
           DW'($urandom), ($urandom % 4) != 0, ($urandom % 700) == 0);
    end
    for (int j = 0; j < 4; j++) idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mram_req_ctrl.md
MRAM_REQ_CTRL -- requirements
Module: mram_req_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the word width of request data, response data and the RAM data/q ports.
REQ-002 Parameter ADDR_WIDTH, default 6, SHALL set the RAM word-address width.
REQ-003 Parameter RSP_DEPTH, default 2, minimum 2, SHALL set the number of read-response buffer entries.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Ports SHALL be as follows:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid is also high.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_data  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  read response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_data  out  DATA_WIDTH  read data.
- ram_we  out  1  write enable to one dual-port RAM port.
- ram_addr  out  ADDR_WIDTH  RAM port address.
- ram_data  out  DATA_WIDTH  RAM port write data.
- ram_q  in  DATA_WIDTH  RAM port read data; registered, valid one cycle after the address is presented.
- busy  out  1  read in flight or response buffered.

Function
REQ-006 Accept SHALL occur when req_valid and req_ready are both high at posedge.
REQ-007 The RAM drive SHALL be combinational: ram_addr = req_addr, ram_data = req_data, ram_we = req_valid & req_ready & req_we.
REQ-008 A write SHALL produce no response.
REQ-009 A read accepted in cycle N SHALL set a 1-bit pending flag; ram_q in cycle N+1 SHALL be pushed into the response buffer at the end of N+1, so rsp_valid is high no earlier than N+2 (fixed latency 2, no bypass).
REQ-010 req_ready SHALL be high iff not in reset and (pending + occupancy - pop) < RSP_DEPTH, where pop = rsp_valid & rsp_ready.
REQ-011 req_ready SHALL NOT depend on req_valid or req_we; writes stall under the same condition as reads.
REQ-012 With rsp_ready held high, back-to-back reads SHALL sustain one accept per cycle at RSP_DEPTH = 2.
REQ-013 The response buffer SHALL be a FIFO with wrapping read/write pointers; responses SHALL leave in request order.
REQ-014 Simultaneous push and pop SHALL be legal at any occupancy, leaving occupancy unchanged.
REQ-015 A push into an empty buffer SHALL raise rsp_valid in the next cycle.
REQ-016 rsp_data SHALL hold the head entry stable while rsp_valid & !rsp_ready.
REQ-017 Overflow SHALL be impossible by construction (REQ-010); the bench asserts occupancy <= RSP_DEPTH.
REQ-018 busy SHALL be high iff the pending flag is set or occupancy != 0.
REQ-019 A read of an address written in the previous accepted cycle SHALL return the new data, because the RAM commits the write before the later read.

Reset
REQ-020 While rst is high: pending = 0, occupancy = 0, pointers = 0, rsp_valid = 0, busy = 0, req_ready = 0, ram_we = 0.
REQ-021 A read in flight or buffered at reset assertion SHALL be discarded with no response; RAM contents SHALL be unaffected.
REQ-022 req_ready SHALL rise in the first cycle after rst deasserts.

Structure
REQ-023 The shared package mram_pkg SHALL hold the default DATA_WIDTH/ADDR_WIDTH constants and the occupancy-count width function, clog2(RSP_DEPTH+1).
REQ-024 The response FIFO SHALL be one sub-module, mram_rsp_fifo, with push/pop/full/empty/count ports; credit logic and the pending flag stay in the top.

Verification
REQ-025 Write addr 5 = 0xA5, then read addr 5 -> rsp_data = 0xA5 with rsp_valid two cycles after the read accept.
REQ-026 Reads of addr 0..3 back-to-back (preloaded 0x10..0x13), rsp_ready = 1 -> req_ready stays 1; responses 0x10..0x13 on four consecutive cycles.
REQ-027 rsp_ready = 0, continuous reads -> exactly 2 accepts, then req_ready = 0 (a pending write also stalls); raising rsp_ready resumes with in-order data and no loss.
REQ-028 rst asserted the cycle after a read accept -> no rsp_valid afterwards; busy = 0; RAM data is intact on a later read.
REQ-029 Write addr 7 = 0x3C, then read addr 7 on the next cycle -> rsp_data = 0x3C.
REQ-030 Random valid/ready traffic for 10k cycles against a reference memory model -> every response matches, occupancy never exceeds RSP_DEPTH.
